// File: rtl/line_buffer_pkg.sv
// Shared defaults, pixel type and bank-index width helper for the multi-row line buffer.
package line_buffer_pkg;

    localparam int LB_DATA_WIDTH = 8;
    localparam int LB_ADDR_WIDTH = 7;
    localparam int LB_LINE_WIDTH = 128;
    localparam int LB_NUM_LINES  = 3;

    typedef logic [LB_DATA_WIDTH-1:0] lb_pix_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int lb_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer_bank.sv
// One single-port read-first RAM bank holding a single image row; read data appears one cycle after ena.
import line_buffer_pkg::*;

module line_buffer_bank #(
    parameter int data_width = LB_DATA_WIDTH,
    parameter int addr_width = LB_ADDR_WIDTH
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wena,
    input  logic [addr_width-1:0] addra,
    input  logic [data_width-1:0] dina,
    output logic [data_width-1:0] douta
);

    logic [data_width-1:0] mem [2**addr_width];

    // Read-first: the old word is captured in the same edge that overwrites it.
    always_ff @(posedge clka) begin
        if (ena) begin
            douta <= mem[addra];
            if (wena) begin
                mem[addra] <= dina;
            end
        end
    end

endmodule

// File: rtl/line_buffer_multi.sv
// Multi-row streaming line buffer emitting a num_lines-high pixel column per enabled cycle.
// Optional top-edge zero padding is enabled by defining LINE_BUFFER_MULTI_ZERO_PAD_EN.
import line_buffer_pkg::*;

module line_buffer_multi #(
    parameter int data_width = LB_DATA_WIDTH,
    parameter int addr_width = LB_ADDR_WIDTH,
    parameter int line_width = LB_LINE_WIDTH,
    parameter int num_lines  = LB_NUM_LINES
) (
    input  logic                            clka,
    input  logic                            rsta,
    input  logic                            ena,
    input  logic                            sofa,
    input  logic [data_width-1:0]           dina,
    output logic [num_lines*data_width-1:0] douta,
    output logic                            valida,
    output logic                            eola
);

    localparam int NB = num_lines - 1;
    localparam int BW = lb_idx_w(NB);
    localparam int RW = lb_idx_w(num_lines);
    localparam logic [addr_width-1:0] COL_LAST  = addr_width'(line_width - 1);
    localparam logic [BW-1:0]         BANK_LAST = BW'(NB - 1);
    localparam logic [RW-1:0]         ROWS_FULL = RW'(NB);

    logic [addr_width-1:0] col, col_cur;
    logic [BW-1:0]         wr_bank, bank_cur, bank_p1;
    logic [RW-1:0]         rows_filled, rows_cur;
    logic [data_width-1:0] pix_p1;
    logic [NB-1:0]         lane_live_nxt, lane_live_p1;
    logic [data_width-1:0] bank_rd [NB];
    logic                  bank_en;

    assign bank_en = ena & ~rsta;

    // Start of frame restarts the counters for the pixel that carries it.
    always_comb begin
        col_cur  = sofa ? '0 : col;
        bank_cur = sofa ? '0 : wr_bank;
        rows_cur = sofa ? '0 : rows_filled;
        lane_live_nxt = '1;
`ifdef LINE_BUFFER_MULTI_ZERO_PAD_EN
        for (int k = 1; k <= NB; k++) begin
            lane_live_nxt[k-1] = (RW'(k) <= rows_cur);
        end
`endif
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        line_buffer_bank #(
            .data_width(data_width),
            .addr_width(addr_width)
        ) u_bank (
            .clka (clka),
            .ena  (bank_en),
            .wena (bank_cur == BW'(g)),
            .addra(col_cur),
            .dina (dina),
            .douta(bank_rd[g])
        );
    end

    // Stage p0 -> p1: counters advance, current pixel and lane routing are registered.
    always_ff @(posedge clka) begin
        if (rsta) begin
            col          <= '0;
            wr_bank      <= '0;
            rows_filled  <= '0;
            bank_p1      <= '0;
            pix_p1       <= '0;
            lane_live_p1 <= '0;
            valida       <= 1'b0;
            eola         <= 1'b0;
        end else if (ena) begin
            if (col_cur == COL_LAST) begin
                col         <= '0;
                wr_bank     <= (bank_cur == BANK_LAST) ? '0 : bank_cur + 1'b1;
                rows_filled <= (rows_cur == ROWS_FULL) ? rows_cur : rows_cur + 1'b1;
            end else begin
                col         <= col_cur + 1'b1;
                wr_bank     <= bank_cur;
                rows_filled <= rows_cur;
            end
            bank_p1      <= bank_cur;
            pix_p1       <= dina;
            lane_live_p1 <= lane_live_nxt;
`ifdef LINE_BUFFER_MULTI_ZERO_PAD_EN
            valida       <= 1'b1;
`else
            valida       <= (rows_cur == ROWS_FULL);
`endif
            eola         <= (col_cur == COL_LAST);
        end else begin
            valida <= 1'b0;
            eola   <= 1'b0;
        end
    end

    // Lane k reads the bank written k rows ago; the bank being written holds the oldest row.
    always_comb begin
        logic [BW-1:0] idx;
        douta = '0;
        douta[0 +: data_width] = pix_p1;
        for (int k = 1; k <= NB; k++) begin
            idx = BW'((int'(bank_p1) + NB - k) % NB);
            douta[k*data_width +: data_width] = lane_live_p1[k-1] ? bank_rd[idx] : '0;
        end
    end

endmodule

// File: doc/line_buffer_multi.md
# line_buffer_multi

Multi-row streaming line buffer for the image front end of the accelerator. It accepts one pixel per enabled cycle in raster order and stores the previous `num_lines-1` image rows in rotating single-port banks. It emits a vertical column of `num_lines` pixels (the current pixel plus the same column from each stored row) to feed the K×K window/convolution stage. It replaces the single-row `line_buffer` wherever more than one row of history is needed.

## Interface
- `data_width`, 8, bits per pixel
- `addr_width`, 7, column address width
- `line_width`, 128, pixels per image row, 2 ≤ `line_width` ≤ 2^`addr_width`
- `num_lines`, 3, output column height, ≥ 2; `num_lines-1` banks instantiated
- `clka`  in  1  system clock; single clock domain
- `rsta`  in  1  reset, synchronous, active-high
- `ena`  in  1  pixel valid; the block advances only when high
- `sofa`  in  1  start of frame, qualified by `ena`; marks the pixel as row 0, col 0
- `dina`  in  `data_width`  input pixel
- `douta`  out  `num_lines*data_width`  column; lane k = bits [k*data_width +: data_width]; lane 0 = current row, lane k = k rows above
- `valida`  out  1  `douta` valid
- `eola`  out  1  `douta` is the last column of a row (col = `line_width-1`)

## Operation
- State: `col` (0..`line_width-1`), `wr_bank` (0..`num_lines-2`), `rows_filled` (0..`num_lines-1`, saturating).
- Enabled cycle (`ena`=1): all banks are read at `col`, and `dina` is written to bank `wr_bank` at `col`. Reads are read-first, so the old contents are returned.
- Lane mapping on the next cycle:
  - lane 0 = registered `dina`.
  - lane k = old data of bank (`wr_bank`−k) mod (`num_lines`−1), for k = 1..`num_lines`−1.
  - Bank `wr_bank` itself supplies the oldest lane.
- Column wrap: when `col` = `line_width-1` on an enabled cycle:
  - `col` → 0.
  - `wr_bank` increments modulo `num_lines-1`.
  - `rows_filled` increments, saturating at `num_lines-1`.
- `ena`=0: no counter, bank or `douta` change; `valida` goes low on the next cycle.
- `sofa` with `ena`: the pixel is processed as col 0 with `rows_filled`=0 and `wr_bank`=0. Counters then continue from col 1. Any partial row is discarded. Bank contents are not cleared.
- `valida` (next cycle) = `ena` & (`rows_filled` == `num_lines-1`), evaluated on the pixel's cycle. `sofa` forces `rows_filled`=0 for this evaluation.
- `eola` is registered alongside `valida`. It is high when the pixel's `col` was `line_width-1`, regardless of `valida`.
- Reset (`rsta`, any cycle including mid-line): next edge sets `col`=0, `wr_bank`=0, `rows_filled`=0, `douta`=0, `valida`=0, `eola`=0. RAM contents are retained but never exposed, because `rows_filled` gates validity. `rsta` overrides `ena` and `sofa`.

## Timing
- Latency: 1 cycle from the `ena` edge to `douta`/`valida`/`eola`.
- Throughput: 1 pixel per clock, no backpressure; the downstream stage must accept every `valida` beat.
- Width arithmetic:
  - The `col` compare is against `line_width-1` at `addr_width` bits.
  - `wr_bank` is `$clog2(num_lines-1)` bits (min 1); the modulo is explicit, not a power-of-two wrap.
- `douta` holds its last value while `ena`=0 (not zeroed).

## Configuration
- `LINE_BUFFER_MULTI_ZERO_PAD_EN` defined:
  - `valida` = `ena` from the first pixel of the frame.
  - Lanes k > `rows_filled` are forced to 0, giving top-edge zero padding.
- Not defined: no padding; `valida` stays low for the first `num_lines-1` rows after reset or `sofa`.

## Structure
- Package `line_buffer_pkg` holds:
  - the default parameters (`LB_DATA_WIDTH`, `LB_ADDR_WIDTH`, `LB_LINE_WIDTH`, `LB_NUM_LINES`);
  - the `lb_pix_t` pixel typedef;
  - a bank-index width function.
- Sub-module `line_buffer_bank`: one single-port, read-first RAM bank (`ena`/`wena`/`addra`/`dina`/`douta`, 1-cycle read). It is instantiated `num_lines-1` times in a generate loop; the top holds the counters and lane muxing.

## Test plan
Bench configuration for all scenarios: `num_lines`=3, `line_width`=4, `data_width`=8; pixel value = row·16 + col.
- Reset: hold `rsta` 2 cycles with `ena`=1 → `douta`=0, `valida`=0, `eola`=0 afterwards.
- Fill:
  - Stream rows 0–2 from `sofa`. The first `valida` follows the pixel 0x20, with `douta` lanes {2,1,0} = {0x00,0x10,0x20}.
  - `eola` is high with lanes {0x03,0x13,0x23}.
- Bank rotation: continue into row 3 → pixel 0x31 gives lanes {0x11,0x21,0x31}; row 4 col 0 gives {0x20,0x30,0x40}.
- Gaps: drop `ena` for 5 cycles at row 2 col 2 → `valida` low and `douta` held; on resume the next beat is {0x03? no: 0x02,0x12,0x22}, i.e. lanes {0x02,0x12,0x22}, with no skipped column.
- `sofa` mid-line: assert at row 3 col 2 → `valida` stays low for the next 8 pixels, then resumes with correct lanes built from the new frame only.
- Pad macro defined: the first pixel 0x00 gives `valida`=1 and lanes {0,0,0x00}; row 1 col 1 gives {0,0x01,0x11}.
